upg_session_ctrl: RTL
=====================

Name: upg_session_ctrl

Overview:
- Sequences UART programming sessions for the single-cycle MIPS top.
- Debounces the start_pg button and drives the UART programmer reset.
- Holds the CPU in reset while a session is in progress.
- After the programmer reports done, holds the CPU in reset for a short flush window, then releases it automatically. No fpga_rst press is needed to run the new image.
- Sits in the top level between the board pins, the UART programmer instance and the CPU-wide reset net. Replaces the ad-hoc upg_rst register.

Parameters:
DEB_CYC, 1000000, consecutive fpga_clk cycles start_pg must be high before a press is accepted (>=2)
POST_CYC, 16, fpga_clk cycles the CPU stays in reset after programming ends (>=1)
TIMEOUT_CYC, 50000000, idle cycles in PROG before abort (used only with UPG_TIMEOUT_EN)

Ports:
fpga_clk  input  1  system clock
fpga_rst  input  1  synchronous reset, active high
start_pg_i  input  1  raw programming button, asynchronous
upg_wen_i  input  1  UART programmer write strobe, upg_clk_o domain
upg_done_i  input  1  UART programmer done level, upg_clk_o domain
upg_rst_o  output  1  reset to UART programmer; 1 = programmer idle
cpu_rst_o  output  1  reset to all CPU modules, active high
mode_o  output  2  current state: 0 RUN, 1 PROG, 2 FLUSH
word_cnt_o  output  16  words written in the current or last session
err_o  output  1  last session aborted by timeout

Behaviour:
- All outputs are registered. One clock: fpga_clk.
- Reset values: state RUN, upg_rst_o=1, cpu_rst_o=1, mode_o=0, word_cnt_o=0, err_o=0. Debounce, flush and timeout counters are cleared.
- fpga_rst overrides everything in every state, including mid-PROG. The next cycle is RUN with the reset values above.
- Synchronizers: start_pg_i, upg_wen_i and upg_done_i each pass through a 2-FF synchronizer before any use.
- Debounce counter:
  - While the synchronized start_pg is 1, it increments and saturates at DEB_CYC.
  - Any 0 sample clears it.
  - press is a 1-cycle pulse, generated only on the cycle the count reaches DEB_CYC. This gives exactly one press per hold, however long the hold is.
  - press latency: 2 sync cycles + DEB_CYC cycles.
- Word counting: a rising edge of synchronized wen increments word_cnt_o. The count saturates at 0xFFFF. Wen pulses are at least 2 fpga_clk cycles high and 2 low.
- Done detection: a rising edge of synchronized done, taken only while in PROG. A done level already high on PROG entry is ignored until it falls and rises again.
- State RUN (mode 0):
  - upg_rst_o=1.
  - cpu_rst_o=0 from the cycle after reset release.
  - On press: go to PROG. Set upg_rst_o=0 and cpu_rst_o=1; clear word_cnt_o and err_o.
- State PROG (mode 1):
  - upg_rst_o=0, cpu_rst_o=1.
  - press is ignored.
  - On done rising edge: go to FLUSH. Set upg_rst_o=1 and load the flush counter with POST_CYC.
- State FLUSH (mode 2):
  - upg_rst_o=1, cpu_rst_o=1.
  - press is ignored.
  - The flush counter decrements each cycle. On the cycle it reaches 0, go to RUN; cpu_rst_o=0 from the next cycle.
  - cpu_rst_o is high for exactly POST_CYC cycles in FLUSH.
- Simultaneous events:
  - Wen edge and done edge in the same cycle: the word is counted and the state moves to FLUSH.
  - press in the same cycle as the FLUSH to RUN transition: ignored.
  - A button held from PROG through RUN does not retrigger until it is released and pressed again.
- mode_o always equals the state encoding. State encoding 3 is unreachable; if entered, the next state is RUN.

Optional Feature:
- Macro: UPG_TIMEOUT_EN.
- Defined:
  - In PROG, an idle counter clears on PROG entry and on every wen edge, and otherwise increments.
  - On reaching TIMEOUT_CYC, go to FLUSH with err_o=1 and upg_rst_o=1.
  - err_o holds until the next PROG entry or fpga_rst.
- Not defined: PROG waits indefinitely for done, err_o is tied to 0, and no timeout counter is built.

Test Plan:
All tests use DEB_CYC=4 and POST_CYC=3; test 6 also uses TIMEOUT_CYC=20.
1. Hold fpga_rst=1 for 2 cycles, then release -> during reset upg_rst_o=1, cpu_rst_o=1, mode_o=0, word_cnt_o=0; one cycle after release cpu_rst_o=0.
2. Bounce start_pg high 3 cycles, low 1, high 2, low; then high 10 cycles -> no transition during the bounce. The 10-cycle hold enters PROG exactly once, 6 cycles after the rising edge: mode_o=1, upg_rst_o=0, cpu_rst_o=1.
3. In PROG, send 5 wen pulses (3 high / 3 low each), then raise done -> word_cnt_o=5. FLUSH is entered 3 cycles after the done edge with upg_rst_o=1. cpu_rst_o stays 1 for 3 cycles, then mode_o=0 and cpu_rst_o=0.
4. Assert fpga_rst after 2 wen pulses in PROG -> next cycle mode_o=0, upg_rst_o=1, word_cnt_o=0. A later done rise causes no transition.
5. Hold start_pg continuously from press through PROG, FLUSH and RUN, with done pulsed mid-way -> exactly one PROG entry. After release and a fresh 10-cycle press, PROG is re-entered with word_cnt_o reset to 0.
6. With UPG_TIMEOUT_EN defined: send 1 wen pulse, then idle 25 cycles in PROG -> FLUSH with err_o=1. Then RUN; err_o stays 1 until the next press.

Source files
------------

// File: rtl/upg_session_ctrl.sv
// UART programming session sequencer: debounces start_pg, gates the programmer and holds the CPU in reset.
// Optional idle timeout in PROG is built only when UPG_TIMEOUT_EN is defined.
module upg_session_ctrl #(
  parameter int DEB_CYC     = 1000000,
  parameter int POST_CYC    = 16,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic        fpga_clk,
  input  logic        fpga_rst,
  input  logic        start_pg_i,
  input  logic        upg_wen_i,
  input  logic        upg_done_i,
  output logic        upg_rst_o,
  output logic        cpu_rst_o,
  output logic [1:0]  mode_o,
  output logic [15:0] word_cnt_o,
  output logic        err_o
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int POST_W = $clog2(POST_CYC + 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYC);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [POST_W-1:0] POST_LOAD = POST_W'(POST_CYC);
  localparam logic [POST_W-1:0] POST_ONE  = POST_W'(1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StProg    = 2'd1,
    StFlush   = 2'd2,
    StIllegal = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic startMeta_q, startSync_q;
  logic wenMeta_q, wenSync_q, wenPrev_q;
  logic doneMeta_q, doneSync_q, donePrev_q;
  logic [DEB_W-1:0]  debCnt_q, debCnt_d;
  logic [POST_W-1:0] flushCnt_q, flushCnt_d;
  logic [15:0]       wordCnt_q, wordCnt_d;
  logic              upgRst_q, upgRst_d;
  logic              cpuRst_q, cpuRst_d;
  logic              press, wenEdge, doneEdge;

`ifdef UPG_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
  logic [IDLE_W-1:0] idleCnt_q, idleCnt_d;
  logic              err_q, err_d;
`endif

  // Every asynchronous input crosses two flops; wen and done keep a third for edge detection.
  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      {startMeta_q, startSync_q} <= '0;
      {wenMeta_q, wenSync_q, wenPrev_q} <= '0;
      {doneMeta_q, doneSync_q, donePrev_q} <= '0;
    end else begin
      startMeta_q <= start_pg_i;
      startSync_q <= startMeta_q;
      wenMeta_q   <= upg_wen_i;
      wenSync_q   <= wenMeta_q;
      wenPrev_q   <= wenSync_q;
      doneMeta_q  <= upg_done_i;
      doneSync_q  <= doneMeta_q;
      donePrev_q  <= doneSync_q;
    end
  end

  // The debounce count saturates, so press fires once per hold however long it lasts.
  assign press    = startSync_q && (debCnt_q == DEB_LAST);
  assign wenEdge  = wenSync_q & ~wenPrev_q;
  assign doneEdge = doneSync_q & ~donePrev_q;

  always_comb begin
    state_d    = state_q;
    upgRst_d   = upgRst_q;
    cpuRst_d   = cpuRst_q;
    flushCnt_d = flushCnt_q;
    wordCnt_d  = wordCnt_q;
    debCnt_d   = '0;
`ifdef UPG_TIMEOUT_EN
    idleCnt_d  = idleCnt_q;
    err_d      = err_q;
`endif

    if (startSync_q)
      debCnt_d = (debCnt_q == DEB_MAX) ? debCnt_q : debCnt_q + 1'b1;
    if (wenEdge && (wordCnt_q != 16'hFFFF))
      wordCnt_d = wordCnt_q + 16'd1;

    case (state_q)
      StRun: begin
        upgRst_d = 1'b1;
        cpuRst_d = 1'b0;
        if (press) begin
          state_d   = StProg;
          upgRst_d  = 1'b0;
          cpuRst_d  = 1'b1;
          wordCnt_d = '0;
`ifdef UPG_TIMEOUT_EN
          err_d     = 1'b0;
          idleCnt_d = '0;
`endif
        end
      end
      StProg: begin
        upgRst_d = 1'b0;
        cpuRst_d = 1'b1;
`ifdef UPG_TIMEOUT_EN
        idleCnt_d = wenEdge ? '0 : idleCnt_q + 1'b1;
`endif
        if (doneEdge) begin
          state_d    = StFlush;
          upgRst_d   = 1'b1;
          flushCnt_d = POST_LOAD;
        end
`ifdef UPG_TIMEOUT_EN
        else if (idleCnt_d == IDLE_MAX) begin
          state_d    = StFlush;
          upgRst_d   = 1'b1;
          flushCnt_d = POST_LOAD;
          err_d      = 1'b1;
        end
`endif
      end
      StFlush: begin
        upgRst_d   = 1'b1;
        cpuRst_d   = 1'b1;
        flushCnt_d = flushCnt_q - 1'b1;
        if (flushCnt_q <= POST_ONE) begin
          state_d    = StRun;
          cpuRst_d   = 1'b0;
          flushCnt_d = '0;
        end
      end
      default: begin
        state_d    = StRun;
        upgRst_d   = 1'b1;
        cpuRst_d   = 1'b1;
        flushCnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      state_q    <= StRun;
      upgRst_q   <= 1'b1;
      cpuRst_q   <= 1'b1;
      flushCnt_q <= '0;
      wordCnt_q  <= '0;
      debCnt_q   <= '0;
`ifdef UPG_TIMEOUT_EN
      idleCnt_q  <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      upgRst_q   <= upgRst_d;
      cpuRst_q   <= cpuRst_d;
      flushCnt_q <= flushCnt_d;
      wordCnt_q  <= wordCnt_d;
      debCnt_q   <= debCnt_d;
`ifdef UPG_TIMEOUT_EN
      idleCnt_q  <= idleCnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign upg_rst_o  = upgRst_q;
  assign cpu_rst_o  = cpuRst_q;
  assign mode_o     = state_q;
  assign word_cnt_o = wordCnt_q;
`ifdef UPG_TIMEOUT_EN
  assign err_o      = err_q;
`else
  // Constant 0 for any legal TIMEOUT_CYC.
  assign err_o      = (TIMEOUT_CYC < 0);
`endif

endmodule
